// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared definitions for the CPU memory-port arbiter: FSM state codes,
// operation codes and default bus widths.
package cpu_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OP_READ  = 1'b0,
    ARB_OP_WRITE = 1'b1
  } arb_op_e;

  localparam int ARB_ADDR_SIZE = 32;
  localparam int ARB_DATA_SIZE = 32;
  localparam int ARB_TIMEOUT   = 15;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester found when
// scanning upward from last_idx+1 with wrap-around.
module cpu_mem_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // The second loop overrides the first, so cores above last_idx always beat
  // the wrapped-around ones; within each group the lowest index wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i <= int'(last_idx))) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(last_idx))) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between CPU_QUANTITY cores,
// with a per-transaction watchdog that aborts a stalled memory handshake.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int CPU_QUANTITY = 2,
  parameter int ADDR_SIZE    = ARB_ADDR_SIZE,
  parameter int DATA_SIZE    = ARB_DATA_SIZE,
  parameter int TIMEOUT      = ARB_TIMEOUT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CPU_QUANTITY-1:0]         req_rd,
  input  logic [CPU_QUANTITY-1:0]         req_wr,
  input  logic [CPU_QUANTITY*ADDR_SIZE-1:0] req_addr,
  input  logic [CPU_QUANTITY*DATA_SIZE-1:0] req_data,
  output logic [CPU_QUANTITY-1:0]         grant,
  output logic [CPU_QUANTITY-1:0]         done,
  output logic [DATA_SIZE-1:0]            rd_data,
  output logic [ADDR_SIZE-1:0]            mem_addr,
  output logic [DATA_SIZE-1:0]            mem_wdata,
  output logic                            mem_rd_q,
  output logic                            mem_wr_q,
  input  logic [DATA_SIZE-1:0]            mem_rdata,
  input  logic                            mem_rd_dn,
  input  logic                            mem_wr_dn,
  output logic                            bus_busy,
  output logic                            timeout_err
);

  localparam int IW = idx_width(CPU_QUANTITY);

  arb_state_e                state_q, state_d;
  arb_op_e                   op_q, op_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [IW-1:0]             last_idx_q, last_idx_d;
  logic [ADDR_SIZE-1:0]      addr_q, addr_d;
  logic [DATA_SIZE-1:0]      wdata_q, wdata_d;
  logic [DATA_SIZE-1:0]      rd_data_q, rd_data_d;
  logic [CPU_QUANTITY-1:0]   grant_q, grant_d;
  logic [CPU_QUANTITY-1:0]   done_q, done_d;
  logic                      busy_q, busy_d;
  logic                      terr_q, terr_d;
  logic                      rd_req_q, rd_req_d;
  logic                      wr_req_q, wr_req_d;
  logic [7:0]                wd_cnt_q, wd_cnt_d;

  logic                      pick_valid;
  logic [IW-1:0]             pick_idx;
  logic                      op_done;

  cpu_mem_arbiter_rr_pick #(
    .N  (CPU_QUANTITY),
    .IW (IW)
  ) u_rr_pick (
    .req      (req_rd | req_wr),
    .last_idx (last_idx_q),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  assign op_done = (op_q == ARB_OP_READ) ? mem_rd_dn : mem_wr_dn;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    grant_d    = grant_q;
    done_d     = '0;
    busy_d     = busy_q;
    terr_d     = terr_q;
    rd_req_d   = rd_req_q;
    wr_req_d   = wr_req_q;
    wd_cnt_d   = wd_cnt_q;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          idx_d             = pick_idx;
          addr_d            = req_addr[pick_idx*ADDR_SIZE +: ADDR_SIZE];
          wdata_d           = req_data[pick_idx*DATA_SIZE +: DATA_SIZE];
          // A core raising both lines gets its read first; the write waits.
          op_d              = req_rd[pick_idx] ? ARB_OP_READ : ARB_OP_WRITE;
          rd_req_d          = req_rd[pick_idx];
          wr_req_d          = ~req_rd[pick_idx];
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          busy_d            = 1'b1;
          wd_cnt_d          = '0;
          state_d           = ARB_ISSUE;
        end
      end

      ARB_ISSUE: begin
        if (op_done) begin
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          if (op_q == ARB_OP_READ) begin
            rd_data_d = mem_rdata;
          end
          done_d  = grant_q;
          state_d = ARB_RELEASE;
        end else if (wd_cnt_q == 8'(TIMEOUT - 1)) begin
          rd_req_d  = 1'b0;
          wr_req_d  = 1'b0;
          terr_d    = 1'b1;
          rd_data_d = '1;
          done_d    = grant_q;
          state_d   = ARB_RELEASE;
        end else begin
          wd_cnt_d = wd_cnt_q + 8'd1;
        end
      end

      ARB_RELEASE: begin
        grant_d    = '0;
        busy_d     = 1'b0;
        last_idx_d = idx_q;
        state_d    = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Bus-side registers move on the falling edge of clk.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      op_q       <= ARB_OP_READ;
      idx_q      <= '0;
      last_idx_q <= IW'(CPU_QUANTITY - 1);
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      terr_q     <= 1'b0;
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      wd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      terr_q     <= terr_d;
      rd_req_q   <= rd_req_d;
      wr_req_q   <= wr_req_d;
      wd_cnt_q   <= wd_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign rd_data     = rd_data_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_rd_q    = rd_req_q;
  assign mem_wr_q    = wr_req_q;
  assign bus_busy    = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: directed scenarios plus randomized
// traffic scored against a transaction-level round-robin and memory model.
module tb_cpu_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_rd, req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    grant, done;
  logic [DW-1:0]   rd_data, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_rd_q, mem_wr_q, mem_rd_dn, mem_wr_dn;
  logic            bus_busy, timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mem_m [logic [AW-1:0]];

  cpu_mem_arbiter #(
    .CPU_QUANTITY (N),
    .ADDR_SIZE    (AW),
    .DATA_SIZE    (DW),
    .TIMEOUT      (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .grant       (grant),
    .done        (done),
    .rd_data     (rd_data),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rd_q    (mem_rd_q),
    .mem_wr_q    (mem_wr_q),
    .mem_rdata   (mem_rdata),
    .mem_rd_dn   (mem_rd_dn),
    .mem_wr_dn   (mem_wr_dn),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs;
    req_rd = '0; req_wr = '0; req_addr = '0; req_data = '0;
    mem_rdata = '0; mem_rd_dn = 1'b0; mem_wr_dn = 1'b0;
  endtask

  task automatic do_reset;
    @(posedge clk);
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    rst = 1'b1;
  endtask

  task automatic set_core(input int i, input logic rd, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_rd[i] = rd;
    req_wr[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return ~a ^ 32'h5A5A_0000;
  endfunction

  task automatic test_reset;
    @(posedge clk);
    rst = 1'b0;
    clear_inputs();
    set_core(0, 1'b1, 1'b0, 32'h100, 32'h0);
    set_core(1, 1'b1, 1'b0, 32'h200, 32'h0);
    set_core(2, 1'b1, 1'b0, 32'h300, 32'h0);
    repeat (2) @(posedge clk);
    n_cmp++;
    if ({grant, done, bus_busy, mem_rd_q, mem_wr_q, timeout_err} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: grant=%b done=%b busy=%b rd_q=%b wr_q=%b terr=%b required all 0",
               grant, done, bus_busy, mem_rd_q, mem_wr_q, timeout_err);
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, rd_data} !== '0) begin
      n_err++;
      $display("FAIL reset_data: addr=%h wdata=%h rd_data=%h required 0", mem_addr, mem_wdata, rd_data);
    end
    rst = 1'b1;
    @(posedge clk);
    n_cmp++;
    if (grant !== 3'b001 || mem_addr !== 32'h100 || mem_rd_q !== 1'b1) begin
      n_err++;
      $display("FAIL reset_first_pick: grant=%b addr=%h rd_q=%b required 001/00000100/1", grant, mem_addr, mem_rd_q);
    end
  endtask

  task automatic test_single_read;
    do_reset();
    set_core(0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    n_cmp++;
    if (grant !== 3'b001 || mem_rd_q !== 1'b1 || mem_wr_q !== 1'b0 || bus_busy !== 1'b1 || mem_addr !== 32'h10) begin
      n_err++;
      $display("FAIL read_grant: grant=%b rd_q=%b wr_q=%b busy=%b addr=%h required 001/1/0/1/10",
               grant, mem_rd_q, mem_wr_q, bus_busy, mem_addr);
    end
    @(posedge clk);
    n_cmp++;
    if (done !== 3'b000) begin
      n_err++;
      $display("FAIL read_early_done: done=%b required 000", done);
    end
    mem_rd_dn = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    @(posedge clk);
    n_cmp++;
    if (done !== 3'b001 || rd_data !== 32'hDEADBEEF || mem_rd_q !== 1'b0) begin
      n_err++;
      $display("FAIL read_done: done=%b rd_data=%h rd_q=%b required 001/deadbeef/0", done, rd_data, mem_rd_q);
    end
    mem_rd_dn = 1'b0;
    mem_rdata = '0;
    req_rd[0] = 1'b0;
    @(posedge clk);
    n_cmp++;
    if (done !== 3'b000 || grant !== 3'b000 || bus_busy !== 1'b0 || rd_data !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL read_release: done=%b grant=%b busy=%b rd_data=%h required 000/000/0/deadbeef",
               done, grant, bus_busy, rd_data);
    end
  endtask

  task automatic test_alternate_writes;
    logic [N-1:0] exp_g;
    logic [N-1:0] prev_g;
    int ng;
    do_reset();
    set_core(0, 1'b0, 1'b1, 32'h1000, 32'hA0A0_0000);
    set_core(1, 1'b0, 1'b1, 32'h2000, 32'hB1B1_1111);
    exp_g  = 3'b001;
    prev_g = '0;
    ng     = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(posedge clk);
      if (prev_g == '0 && grant != '0) begin
        n_cmp++;
        if (grant !== exp_g || mem_wr_q !== 1'b1 ||
            mem_wdata !== ((exp_g == 3'b001) ? 32'hA0A0_0000 : 32'hB1B1_1111)) begin
          n_err++;
          $display("FAIL alt_grant%0d: grant=%b wr_q=%b wdata=%h required grant %b", ng, grant, mem_wr_q, mem_wdata, exp_g);
        end
        exp_g = (exp_g == 3'b001) ? 3'b010 : 3'b001;
        ng++;
      end
      prev_g    = grant;
      mem_wr_dn = mem_wr_q;
    end
    n_cmp++;
    if (ng < 4) begin
      n_err++;
      $display("FAIL alt_count: grants=%0d required 4", ng);
    end
  endtask

  task automatic test_rd_wr_both;
    logic got;
    do_reset();
    set_core(1, 1'b1, 1'b1, 32'h40, 32'h1234_5678);
    @(posedge clk);
    n_cmp++;
    if (grant !== 3'b010 || mem_rd_q !== 1'b1 || mem_wr_q !== 1'b0) begin
      n_err++;
      $display("FAIL both_read_first: grant=%b rd_q=%b wr_q=%b required 010/1/0", grant, mem_rd_q, mem_wr_q);
    end
    mem_rd_dn = 1'b1;
    mem_rdata = 32'h0000_A5A5;
    @(posedge clk);
    n_cmp++;
    if (done !== 3'b010 || rd_data !== 32'h0000_A5A5) begin
      n_err++;
      $display("FAIL both_read_done: done=%b rd_data=%h required 010/0000a5a5", done, rd_data);
    end
    mem_rd_dn = 1'b0;
    req_rd[1] = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(posedge clk);
      got = (grant != '0);
    end
    n_cmp++;
    if (!got || grant !== 3'b010 || mem_wr_q !== 1'b1 || mem_rd_q !== 1'b0 || mem_wdata !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL both_write_later: got=%b grant=%b wr_q=%b rd_q=%b wdata=%h required 1/010/1/0/12345678",
               got, grant, mem_wr_q, mem_rd_q, mem_wdata);
    end
    mem_wr_dn = 1'b1;
    @(posedge clk);
    n_cmp++;
    if (done !== 3'b010) begin
      n_err++;
      $display("FAIL both_write_done: done=%b required 010", done);
    end
    mem_wr_dn = 1'b0;
    req_wr[1] = 1'b0;
  endtask

  task automatic test_timeout;
    logic early_bad;
    logic got;
    do_reset();
    set_core(0, 1'b1, 1'b0, 32'h20, 32'h0);
    @(posedge clk);
    n_cmp++;
    if (grant !== 3'b001 || mem_rd_q !== 1'b1) begin
      n_err++;
      $display("FAIL to_grant: grant=%b rd_q=%b required 001/1", grant, mem_rd_q);
    end
    early_bad = 1'b0;
    for (int k = 2; k <= TO; k++) begin
      @(posedge clk);
      if (mem_rd_q !== 1'b1 || done !== 3'b000 || timeout_err !== 1'b0) early_bad = 1'b1;
      mem_wr_dn = (k == 2);
    end
    n_cmp++;
    if (early_bad) begin
      n_err++;
      $display("FAIL to_wait: transaction ended or flagged early, required held for %0d cycles", TO);
    end
    @(posedge clk);
    n_cmp++;
    if (done !== 3'b001 || timeout_err !== 1'b1 || rd_data !== 32'hFFFF_FFFF || mem_rd_q !== 1'b0) begin
      n_err++;
      $display("FAIL to_abort: done=%b terr=%b rd_data=%h rd_q=%b required 001/1/ffffffff/0",
               done, timeout_err, rd_data, mem_rd_q);
    end
    req_rd[0] = 1'b0;
    @(posedge clk);
    n_cmp++;
    if (done !== 3'b000 || grant !== 3'b000 || timeout_err !== 1'b1) begin
      n_err++;
      $display("FAIL to_sticky: done=%b grant=%b terr=%b required 000/000/1", done, grant, timeout_err);
    end
    set_core(1, 1'b0, 1'b1, 32'h24, 32'h0BAD_F00D);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(posedge clk);
      got = (grant != '0);
    end
    mem_wr_dn = 1'b1;
    @(posedge clk);
    n_cmp++;
    if (!got || done !== 3'b010 || timeout_err !== 1'b1) begin
      n_err++;
      $display("FAIL to_next_served: got=%b done=%b terr=%b required 1/010/1", got, done, timeout_err);
    end
    mem_wr_dn = 1'b0;
    req_wr[1] = 1'b0;
  endtask

  task automatic test_drop_after_grant;
    do_reset();
    set_core(2, 1'b0, 1'b1, 32'h80, 32'hCAFE_0001);
    @(posedge clk);
    n_cmp++;
    if (grant !== 3'b100 || mem_wr_q !== 1'b1 || mem_wdata !== 32'hCAFE_0001) begin
      n_err++;
      $display("FAIL drop_grant: grant=%b wr_q=%b wdata=%h required 100/1/cafe0001", grant, mem_wr_q, mem_wdata);
    end
    req_wr[2] = 1'b0;
    @(posedge clk);
    n_cmp++;
    if (grant !== 3'b100 || mem_wr_q !== 1'b1 || done !== 3'b000) begin
      n_err++;
      $display("FAIL drop_hold: grant=%b wr_q=%b done=%b required 100/1/000", grant, mem_wr_q, done);
    end
    mem_wr_dn = 1'b1;
    @(posedge clk);
    n_cmp++;
    if (done !== 3'b100 || mem_wr_q !== 1'b0) begin
      n_err++;
      $display("FAIL drop_done: done=%b wr_q=%b required 100/0", done, mem_wr_q);
    end
    mem_wr_dn = 1'b0;
    @(posedge clk);
    n_cmp++;
    if (done !== 3'b000 || grant !== 3'b000) begin
      n_err++;
      $display("FAIL drop_release: done=%b grant=%b required 000/000", done, grant);
    end
  endtask

  task automatic test_reset_mid_issue;
    logic saw_done;
    do_reset();
    set_core(0, 1'b1, 1'b0, 32'h30, 32'h0);
    @(posedge clk);
    set_core(1, 1'b1, 1'b0, 32'h34, 32'h0);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (mem_rd_q !== 1'b0 || grant !== 3'b000 || bus_busy !== 1'b0 || done !== 3'b000 || mem_addr !== '0) begin
      n_err++;
      $display("FAIL async_reset: rd_q=%b grant=%b busy=%b done=%b addr=%h required all 0",
               mem_rd_q, grant, bus_busy, done, mem_addr);
    end
    @(posedge clk);
    saw_done = (done != '0);
    rst = 1'b1;
    @(posedge clk);
    saw_done = saw_done | (done != '0);
    n_cmp++;
    if (grant !== 3'b001 || mem_addr !== 32'h30 || saw_done) begin
      n_err++;
      $display("FAIL reset_repick: grant=%b addr=%h done_seen=%b required 001/00000030/0", grant, mem_addr, saw_done);
    end
    mem_rd_dn = 1'b1;
    mem_rdata = 32'h1357_9BDF;
    @(posedge clk);
    n_cmp++;
    if (done !== 3'b001 || rd_data !== 32'h1357_9BDF) begin
      n_err++;
      $display("FAIL reset_resume: done=%b rd_data=%h required 001/13579bdf", done, rd_data);
    end
    mem_rd_dn = 1'b0;
    clear_inputs();
  endtask

  task automatic test_random;
    logic [N-1:0]  rd_r, wr_r, prev_req, prev_grant, onehot;
    logic [AW-1:0] addr_r [N];
    logic [DW-1:0] data_r [N];
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data, rdv;
    logic          exp_active, exp_rd, done_due, prev_idle;
    int            exp_owner, model_last, lat, n_txn, kind;
    do_reset();
    rd_r = '0; wr_r = '0; prev_req = '0; prev_grant = '0; onehot = '0;
    exp_active = 1'b0; exp_rd = 1'b0; done_due = 1'b0; prev_idle = 1'b1;
    exp_owner = 0; model_last = N - 1; lat = 0; n_txn = 0;
    exp_addr = '0; exp_data = '0; rdv = '0;
    for (int i = 0; i < N; i++) begin
      addr_r[i] = '0;
      data_r[i] = '0;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(posedge clk);
      n_cmp++;
      if (!$onehot0(grant) || (mem_rd_q && mem_wr_q) || ((done & ~grant) != '0) || bus_busy !== (grant != '0)) begin
        n_err++;
        $display("FAIL rnd_invariant cyc %0d: grant=%b done=%b rd_q=%b wr_q=%b busy=%b",
                 cyc, grant, done, mem_rd_q, mem_wr_q, bus_busy);
      end
      onehot = '0;
      onehot[exp_owner] = 1'b1;
      if (done_due) begin
        n_cmp++;
        if (done !== onehot || (exp_rd && rd_data !== rdv)) begin
          n_err++;
          $display("FAIL rnd_done cyc %0d: done=%b rd_data=%h required %b/%h", cyc, done, rd_data, onehot, rdv);
        end
        $display("txn %0d core %0d %s addr=%h data=%h", n_txn, exp_owner, exp_rd ? "RD" : "WR",
                 exp_addr, exp_rd ? rdv : exp_data);
        if (!exp_rd) mem_m[exp_addr] = exp_data;
        if (exp_rd) rd_r[exp_owner] = 1'b0;
        else        wr_r[exp_owner] = 1'b0;
        model_last = exp_owner;
        exp_active = 1'b0;
        done_due   = 1'b0;
        n_txn++;
      end else begin
        n_cmp++;
        if (done !== '0) begin
          n_err++;
          $display("FAIL rnd_spurious_done cyc %0d: done=%b required 000", cyc, done);
        end
      end
      if (prev_idle) begin
        n_cmp++;
        if ((grant != '0) !== (prev_req != '0)) begin
          n_err++;
          $display("FAIL rnd_idle_pick cyc %0d: grant=%b with requests %b", cyc, grant, prev_req);
        end
      end
      if (prev_grant == '0 && grant != '0) begin
        exp_owner = -1;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (model_last + k) % N;
          if (prev_req[c] && exp_owner < 0) exp_owner = c;
        end
        if (exp_owner < 0) exp_owner = 0;
        onehot = '0;
        onehot[exp_owner] = 1'b1;
        exp_rd   = rd_r[exp_owner];
        exp_addr = addr_r[exp_owner];
        exp_data = data_r[exp_owner];
        n_cmp++;
        if (grant !== onehot || mem_rd_q !== exp_rd || mem_wr_q !== !exp_rd ||
            mem_addr !== exp_addr || mem_wdata !== exp_data) begin
          n_err++;
          $display("FAIL rnd_grant cyc %0d: grant=%b rd_q=%b addr=%h wdata=%h required %b/%b/%h/%h",
                   cyc, grant, mem_rd_q, mem_addr, mem_wdata, onehot, exp_rd, exp_addr, exp_data);
        end
        exp_active = 1'b1;
        lat = $urandom_range(0, 4);
      end else if (exp_active) begin
        n_cmp++;
        if (grant !== onehot || mem_rd_q !== exp_rd || mem_wr_q !== !exp_rd) begin
          n_err++;
          $display("FAIL rnd_hold cyc %0d: grant=%b rd_q=%b wr_q=%b required %b/%b", cyc, grant, mem_rd_q, mem_wr_q, onehot, exp_rd);
        end
      end
      mem_rd_dn = 1'b0;
      mem_wr_dn = 1'b0;
      if (exp_active && !done_due) begin
        if (lat == 0) begin
          if (exp_rd) begin
            rdv = mem_read(exp_addr);
            mem_rdata = rdv;
            mem_rd_dn = 1'b1;
          end else begin
            mem_wr_dn = 1'b1;
          end
          done_due = 1'b1;
        end else begin
          lat--;
          mem_rdata = $urandom;
          if ($urandom_range(0, 3) == 0) begin
            if (exp_rd) mem_wr_dn = 1'b1;
            else        mem_rd_dn = 1'b1;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!rd_r[i] && !wr_r[i] && cyc < 700 && $urandom_range(0, 2) == 0) begin
          kind = $urandom_range(0, 2);
          rd_r[i] = (kind != 1);
          wr_r[i] = (kind != 0);
          addr_r[i] = AW'($urandom_range(0, 7)) << 2;
          data_r[i] = $urandom;
        end
        set_core(i, rd_r[i], wr_r[i], addr_r[i], data_r[i]);
      end
      prev_req   = rd_r | wr_r;
      prev_idle  = (bus_busy === 1'b0);
      prev_grant = grant;
    end
    n_cmp++;
    if ((rd_r | wr_r) != '0 || n_txn < 20) begin
      n_err++;
      $display("FAIL rnd_drain: pending=%b txns=%0d required 000 and >=20", rd_r | wr_r, n_txn);
    end
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_alternate_writes();
    test_rd_wr_both();
    test_timeout();
    test_drop_after_grant();
    test_reset_mid_issue();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Round-robin arbiter that shares one memory port between CPU_QUANTITY cpu cores.
- Sits between the cores' read/write request lines and the dispatcher's memory service port.
- Serialises requests, holds the memory handshake until it completes and returns done and read data to the granted core.
- Guards the bus with a watchdog so a missing done cannot hang the system.

Parameters:
- CPU_QUANTITY, 2, number of requesting cores (2..16).
- ADDR_SIZE, 32, address width.
- DATA_SIZE, 32, data width.
- TIMEOUT, 15, cycles ISSUE may wait for a memory done before abort (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-low.
- req_rd  in  CPU_QUANTITY  per-core read request, level.
- req_wr  in  CPU_QUANTITY  per-core write request, level.
- req_addr  in  CPU_QUANTITY*ADDR_SIZE  per-core address; core i occupies bits [i*ADDR_SIZE +: ADDR_SIZE].
- req_data  in  CPU_QUANTITY*DATA_SIZE  per-core write data, same packing.
- grant  out  CPU_QUANTITY  one-hot owner of the memory port.
- done  out  CPU_QUANTITY  one-cycle completion pulse to the owner.
- rd_data  out  DATA_SIZE  read data, valid while done is high.
- mem_addr  out  ADDR_SIZE  latched address to memory.
- mem_wdata  out  DATA_SIZE  latched write data.
- mem_rd_q  out  1  read request to memory, level.
- mem_wr_q  out  1  write request to memory, level.
- mem_rdata  in  DATA_SIZE  memory read data.
- mem_rd_dn  in  1  memory read done.
- mem_wr_dn  in  1  memory write done.
- bus_busy  out  1  high from grant until release.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- All registers update on negedge clk, the bus-side convention.
- rst=0 asynchronously forces:
  - state=IDLE;
  - grant, done, mem_rd_q, mem_wr_q, bus_busy, timeout_err = 0;
  - mem_addr, mem_wdata, rd_data = 0;
  - last_idx = CPU_QUANTITY-1, so core 0 has first priority;
  - wd_cnt = 0.
- rst mid-transaction: memory request drops immediately and the transaction is lost; no done is issued.
- IDLE:
  - Pick the first i with req_rd[i]|req_wr[i], scanning from last_idx+1 with wrap modulo CPU_QUANTITY.
  - Latch idx, addr and data; op=READ if req_rd[i], else WRITE. Read wins if both are set, and the write is served on a later grant.
  - On the same edge: grant[i]=1, bus_busy=1, mem_rd_q or mem_wr_q=1, wd_cnt=0, go to ISSUE.
  - Latency: a request sampled at edge k shows grant and mem_*_q after edge k.
  - No request: stay in IDLE, all outputs low.
- ISSUE:
  - Hold the q line, mem_addr and mem_wdata stable.
  - The done matching op (mem_rd_dn for READ, mem_wr_dn for WRITE) ends the transaction:
    - drop q;
    - for READ, rd_data<=mem_rdata (for WRITE, rd_data holds);
    - done[idx]=1 for one cycle;
    - go to RELEASE.
  - A done of the wrong type is ignored.
  - Otherwise wd_cnt++. When wd_cnt==TIMEOUT-1 with no done:
    - drop q;
    - timeout_err=1;
    - rd_data=all ones;
    - done[idx]=1;
    - go to RELEASE.
  - The requester deasserting its request after grant is ignored; the transaction completes.
- RELEASE (exactly one cycle):
  - grant=0, bus_busy=0, done=0, last_idx=idx;
  - go to IDLE.
- Minimum occupancy is 3 cycles per transaction (IDLE, ISSUE, RELEASE). Back-to-back grants are separated by at least one bus_busy-low cycle.
- Fairness: a core still requesting in IDLE after its own done has lowest priority. With all cores requesting, service order is strictly rotating.
- timeout_err clears only on reset.
- Invariants: grant is one-hot or zero; mem_rd_q & mem_wr_q never both 1; done is a subset of grant.

Decomposition:
- Shared include (alongside the states and sizes defines):
  - ARB_IDLE=0, ARB_ISSUE=1, ARB_RELEASE=2 state codes;
  - ARB_OP_READ/ARB_OP_WRITE;
  - the ADDR_SIZE/DATA_SIZE defaults.
- Sub-module rr_pick: combinational round-robin picker taking the request vector and last_idx, giving valid and idx. Reused later for thread-slot arbitration.

Test Plan:
- Reset pulse (rst=0) mid-ISSUE of a read -> mem_rd_q, grant and bus_busy drop without waiting for clk; no done is issued; after release, core 0 is picked first.
- Core 0 read, addr 0x10; memory returns 0xDEADBEEF with mem_rd_dn after 2 cycles -> grant=01 at the next negedge, then done[0] for 1 cycle with rd_data=0xDEADBEEF, then bus_busy=0 for 1 cycle.
- Cores 0 and 1 both request writes continuously -> grants alternate 01,10,01,10; mem_wdata matches each owner's req_data.
- Core 1 asserts req_rd and req_wr together -> read issued first (mem_rd_q=1, mem_wr_q=0); write issued on a later grant.
- Read with mem_wr_dn pulsed but no mem_rd_dn for 15 cycles -> wrong-type done ignored; timeout_err=1; done[0] with rd_data=0xFFFFFFFF; next request still served.
- Requester drops req_wr one cycle after grant -> write still completes on mem_wr_dn and done pulses.
